key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/piano_pkg.sv | 39 +++
 rtl/key_debounce_cell.sv | 59 +++++
 rtl/key_conditioner.sv | 115 +++++++++++
 tb/tb_key_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: constants, FSM state type and key/note helpers shared across
// the piano key path.
package piano_pkg;

  localparam int unsigned KEY_W                   = 7;
  localparam int unsigned CODE_W                  = 3;
  localparam logic [2:0]  NOTE_NONE               = 3'd0;
  localparam int unsigned CLK_HZ                  = 10_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 200_000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } key_state_e;

  // Keep only the highest-index set bit (do beats re ... beats xi).
  function automatic logic [KEY_W-1:0] msb_onehot(input logic [KEY_W-1:0] v);
    logic [KEY_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // One-hot key vector to note number: Key[6]=do=1 ... Key[0]=xi=7, none=0.
  function automatic logic [CODE_W-1:0] note_code(input logic [KEY_W-1:0] onehot);
    logic [CODE_W-1:0] r;
    r = NOTE_NONE;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if (onehot[i]) r = CODE_W'(int'(KEY_W) - i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: 2-flop synchronizer followed by a counter debouncer for
// one push-button.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   key_raw   - raw button input, asynchronous to clk
//   stable    - debounced level, changes only after DEBOUNCE_CYCLES
//               consecutive cycles of disagreement
module key_debounce_cell
  import piano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic stable
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer shift and debounce counter; the counter only runs while the
  // synchronized level disagrees with the accepted level.
  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: turns seven raw piano buttons into a single owned key.
// Each button is synchronized and debounced; an IDLE/HELD FSM keeps the
// first-chosen (highest-priority) key until it is released.
// Ports:
//   CLK, RST    - 10 MHz clock, asynchronous active-high reset
//   Key[6:0]    - raw buttons, Key[6]=do ... Key[0]=xi
//   KeyState    - conditioned key, one-hot or zero
//   KeyCode     - note number of KeyState (do=1 ... xi=7, 0=none)
//   KeyPress    - one-cycle pulse on each new non-zero KeyState
//   PressCount  - saturating press counter, only with KEY_PRESS_CNT_EN
// Build option: define KEY_PRESS_CNT_EN to add PressCount.
module key_conditioner
  import piano_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [KEY_W-1:0]  Key,
  output logic [KEY_W-1:0]  KeyState,
  output logic [CODE_W-1:0] KeyCode,
  output logic              KeyPress
`ifdef KEY_PRESS_CNT_EN
  ,
  output logic [7:0]        PressCount
`endif
);

  logic [KEY_W-1:0] stable;

  key_state_e        state_q, state_d;
  logic [KEY_W-1:0]  key_state_q, key_state_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_press_q, key_press_d;

  // Per-key synchronizer + debouncer.
  for (genvar g = 0; g < int'(KEY_W); g++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (CLK),
      .rst    (RST),
      .key_raw(Key[g]),
      .stable (stable[g])
    );
  end

  // Ownership FSM: the owner is kept while still pressed; on its release the
  // highest remaining key takes over, otherwise fall back to IDLE.
  always_comb begin
    state_d     = state_q;
    key_state_d = key_state_q;
    case (state_q)
      ST_IDLE: begin
        if (|stable) begin
          state_d     = ST_HELD;
          key_state_d = msb_onehot(stable);
        end
      end
      ST_HELD: begin
        if ((stable & key_state_q) == '0) begin
          if (|stable) begin
            key_state_d = msb_onehot(stable);
          end else begin
            state_d     = ST_IDLE;
            key_state_d = '0;
          end
        end
      end
    endcase
    key_code_d  = note_code(key_state_d);
    key_press_d = (key_state_d != '0) && (key_state_d != key_state_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      key_state_q <= '0;
      key_code_q  <= NOTE_NONE;
      key_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_state_q <= key_state_d;
      key_code_q  <= key_code_d;
      key_press_q <= key_press_d;
    end
  end

  assign KeyState = key_state_q;
  assign KeyCode  = key_code_q;
  assign KeyPress = key_press_q;

`ifdef KEY_PRESS_CNT_EN
  logic [7:0] press_count_q, press_count_d;

  // Counts alongside KeyPress, saturating at 255.
  always_comb begin
    press_count_d = press_count_q;
    if (key_press_d && (press_count_q != 8'hFF)) begin
      press_count_d = press_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      press_count_q <= 8'd0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign PressCount = press_count_q;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4.
module tb_key_conditioner;

  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] Key = 7'd0;
  logic [6:0] KeyState;
  logic [2:0] KeyCode;
  logic       KeyPress;
`ifdef KEY_PRESS_CNT_EN
  logic [7:0] PressCount;
`endif

  key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Key     (Key),
    .KeyState(KeyState),
    .KeyCode (KeyCode),
    .KeyPress(KeyPress)
`ifdef KEY_PRESS_CNT_EN
    ,
    .PressCount(PressCount)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int kp_seen = 0;

  // Reference model: raw key history, accepted levels, owner and counter.
  logic [6:0] hist [0:D+1];
  logic [6:0] m_stable;
  logic [6:0] m_ks;
  logic [2:0] m_kc;
  logic       m_kp;
  int         m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= D + 1; i++) hist[i] = 7'd0;
    m_stable = 7'd0;
    m_ks     = 7'd0;
    m_kc     = 3'd0;
    m_kp     = 1'b0;
    m_pc     = 0;
  endtask

  // One clock edge of the model; k is the raw Key sampled at this edge.
  task automatic model_edge(input logic [6:0] k);
    logic [6:0] nks;
    logic       all_diff;
    int         top;
    nks = m_ks;
    if ((m_ks & m_stable) == 7'd0) begin
      top = -1;
      for (int i = 0; i < 7; i++) if (m_stable[i]) top = i;
      nks = 7'd0;
      if (top >= 0) nks[top] = 1'b1;
    end
    m_kp = (nks != 7'd0) && (nks != m_ks);
    if (m_kp && m_pc < 255) m_pc++;
    m_ks = nks;
    m_kc = 3'd0;
    for (int i = 0; i < 7; i++) if (nks[i]) m_kc = 3'(7 - i);
    for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = k;
    // Synchronizer delays by two edges; a level is accepted after D
    // consecutive synchronized samples that all disagree with it.
    for (int b = 0; b < 7; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) m_stable[b] = hist[2][b];
    end
  endtask

  task automatic step(input logic [6:0] k);
    @(negedge CLK);
    Key = k;
    @(posedge CLK);
    model_edge(k);
    #1;
    check("KeyState", 32'(KeyState), 32'(m_ks));
    check("KeyCode", 32'(KeyCode), 32'(m_kc));
    check("KeyPress", 32'(KeyPress), 32'(m_kp));
    check("onehot", 32'($countones(KeyState) <= 1), 32'd1);
`ifdef KEY_PRESS_CNT_EN
    check("PressCount", 32'(PressCount), 32'(m_pc));
`endif
    if (KeyPress) kp_seen++;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_KeyState"}, 32'(KeyState), 32'd0);
    check({tag, "_KeyCode"}, 32'(KeyCode), 32'd0);
    check({tag, "_KeyPress"}, 32'(KeyPress), 32'd0);
`ifdef KEY_PRESS_CNT_EN
    check({tag, "_PressCount"}, 32'(PressCount), 32'd0);
`endif
  endtask

  // Assert RST between edges, hold it over two edges, release just after an edge.
  task automatic pulse_reset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_zero_outputs(tag);
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    logic [6:0] pat;
    int         hold;

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_zero_outputs("reset");
    @(posedge CLK);
    #2;
    RST = 1'b0;

    // Steady press of Key[2]: accepted on the 7th edge, single KeyPress.
    kp_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      step(7'b0000100);
      if (i == 6) check("press_lat_early", 32'(KeyState), 32'd0);
      if (i == 7) begin
        check("press_lat_state", 32'(KeyState), 32'b0000100);
        check("press_lat_code", 32'(KeyCode), 32'd5);
        check("press_lat_pulse", 32'(KeyPress), 32'd1);
      end
    end
    repeat (12) step(7'b0000000);
    check("press_once", 32'(kp_seen), 32'd1);
    check("release_idle", 32'(KeyState), 32'd0);

    // 3-cycle glitch on Key[6] is rejected.
    kp_seen = 0;
    repeat (3) step(7'b1000000);
    repeat (10) begin
      step(7'b0000000);
      check("glitch_state", 32'(KeyState), 32'd0);
    end
    check("glitch_nopress", 32'(kp_seen), 32'd0);

    // Owner Key[3] keeps ownership when Key[6] joins; release hands over.
    repeat (8) step(7'b0001000);
    check("fa_owner", 32'(KeyState), 32'b0001000);
    repeat (10) step(7'b1001000);
    check("fa_keeps", 32'(KeyState), 32'b0001000);
    kp_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      step(7'b1000000);
      if (i == 7) begin
        check("handover_state", 32'(KeyState), 32'b1000000);
        check("handover_code", 32'(KeyCode), 32'd1);
      end
    end
    check("handover_press", 32'(kp_seen), 32'd1);
    repeat (10) step(7'b0000000);

    // Simultaneous Key[6] and Key[0]: do wins; release gives no pulse.
    repeat (8) step(7'b1000001);
    check("prio_state", 32'(KeyState), 32'b1000000);
    kp_seen = 0;
    repeat (10) step(7'b0000000);
    check("prio_release", 32'(KeyState), 32'd0);
    check("prio_nopress", 32'(kp_seen), 32'd0);

    // Reset in HELD with Key[1] held: immediate clear, full re-qualification.
    repeat (8) step(7'b0000010);
    check("held_before_rst", 32'(KeyState), 32'b0000010);
    pulse_reset("rst_held");
    for (int i = 1; i <= 7; i++) begin
      step(7'b0000010);
      if (i == 6) check("requal_early", 32'(KeyState), 32'd0);
      if (i == 7) check("requal_state", 32'(KeyState), 32'b0000010);
    end
    repeat (10) step(7'b0000000);

    // Randomized key activity against the model.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: pat = 7'd0;
        1: begin pat = 7'd0; pat[$urandom_range(0, 6)] = 1'b1; end
        2: pat = 7'($urandom());
        default: pat = Key;
      endcase
      hold = int'($urandom_range(1, 10));
      repeat (hold) step(pat);
    end
    repeat (12) step(7'b0000000);

`ifdef KEY_PRESS_CNT_EN
    // 300 qualified presses saturate the counter.
    pulse_reset("rst_cnt");
    repeat (300) begin
      repeat (8) step(7'b0000001);
      repeat (8) step(7'b0000000);
    end
    check("press_count_sat", 32'(PressCount), 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
